// File: rtl/stretcher_pkg.sv
// Shared types and helpers for the pulse stretcher: FSM state encoding and a
// small max helper used to size the shared cycle timer.
package stretcher_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ON   = 2'd1,
    ST_OFF  = 2'd2
  } stretch_state_t;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/cycle_timer.sv
// Down-counting phase timer: load sets the number of cycles in the phase
// about to start, and done is high during the last cycle of that phase.
module cycle_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] value,
  output logic         done,
  output logic [W-1:0] count
);

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= value;
    end else if (count != '0) begin
      count <= count - W'(1);
    end
  end

  // count holds the cycles remaining including the current one.
  assign done = (count == W'(1));

endmodule

// File: rtl/pulse_stretcher.sv
// Turns single-cycle event strobes into pulses with guaranteed high time and
// low gap; events arriving while busy are queued and replayed one per pulse.
module pulse_stretcher
  import stretcher_pkg::*;
#(
  parameter int ON_CYCLES   = 255,
  parameter int OFF_CYCLES  = 255,
  parameter int MAX_PENDING = 15
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               trig,
  input  logic                               clr_ovf,
  output logic                               out,
  output logic                               busy,
  output logic [$clog2(MAX_PENDING+1)-1:0]   pending,
  output logic                               overflow
);

  localparam int PW = $clog2(MAX_PENDING + 1);
  localparam int TW = $clog2(max_int(ON_CYCLES, OFF_CYCLES) + 1);

  // Handshake: none. trig is a per-cycle strobe, every high cycle is one
  // event; there is no backpressure, excess events are dropped and flagged.

  stretch_state_t state, state_nxt;
  logic           tmr_load;
  logic [TW-1:0]  tmr_value;
  logic           tmr_done;
  logic [TW-1:0]  tmr_count;
  logic           queue_ev;
  logic           start_q;
  logic           drop_ev;

  cycle_timer #(.W(TW)) u_timer (
    .clk   (clk),
    .rst   (rst),
    .load  (tmr_load),
    .value (tmr_value),
    .done  (tmr_done),
    .count (tmr_count)
  );

  always_comb begin
    state_nxt = state;
    tmr_load  = 1'b0;
    tmr_value = TW'(ON_CYCLES);
    queue_ev  = 1'b0;
    start_q   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (trig) begin
          state_nxt = ST_ON;
          tmr_load  = 1'b1;
        end
      end
      ST_ON: begin
        queue_ev = trig;
        if (tmr_done) begin
          state_nxt = ST_OFF;
          tmr_load  = 1'b1;
          tmr_value = TW'(OFF_CYCLES);
        end
      end
      ST_OFF: begin
        if (tmr_done) begin
          // Queued events have priority; a trig in the same cycle joins the queue.
          if (pending != '0) begin
            state_nxt = ST_ON;
            tmr_load  = 1'b1;
            start_q   = 1'b1;
            queue_ev  = trig;
          end else if (trig) begin
            state_nxt = ST_ON;
            tmr_load  = 1'b1;
          end else begin
            state_nxt = ST_IDLE;
          end
        end else begin
          queue_ev = trig;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign drop_ev = queue_ev && !start_q && (pending == PW'(MAX_PENDING));

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      out      <= 1'b0;
      busy     <= 1'b0;
      pending  <= '0;
      overflow <= 1'b0;
    end else begin
      state <= state_nxt;
      out   <= (state_nxt == ST_ON);
      busy  <= (state_nxt != ST_IDLE);
      if (queue_ev && !start_q && !drop_ev) begin
        pending <= pending + PW'(1);
      end else if (start_q && !queue_ev) begin
        pending <= pending - PW'(1);
      end
      if (drop_ev) begin
        overflow <= 1'b1;
      end else if (clr_ovf) begin
        overflow <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_pulse_stretcher.sv
// Directed bench: small instance (4/3/2) for cycle-exact scenarios and a
// default-parameter instance for the long saturation run.
module tb_pulse_stretcher;

  logic       clk = 1'b0;
  logic       rst, trig, clr_ovf;
  logic       out, busy, overflow;
  logic [1:0] pending;

  logic       d_rst, d_trig, d_clr_ovf;
  logic       d_out, d_busy, d_overflow;
  logic [3:0] d_pending;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pulse_stretcher #(.ON_CYCLES(4), .OFF_CYCLES(3), .MAX_PENDING(2)) dut (
    .clk(clk), .rst(rst), .trig(trig), .clr_ovf(clr_ovf),
    .out(out), .busy(busy), .pending(pending), .overflow(overflow)
  );

  pulse_stretcher dut_def (
    .clk(clk), .rst(d_rst), .trig(d_trig), .clr_ovf(d_clr_ovf),
    .out(d_out), .busy(d_busy), .pending(d_pending), .overflow(d_overflow)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Leaves the bench at cycle 0: just after the edge that released reset.
  task automatic reset_dut();
    rst = 1'b1; trig = 1'b0; clr_ovf = 1'b0;
    repeat (2) tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    reset_dut();
    checks++;
    if ({out, busy, pending, overflow} !== 5'b0) begin
      errors++;
      $display("FAIL reset_state: got %b expected 00000", {out, busy, pending, overflow});
    end
  endtask

  task automatic test_single();
    logic [4:0] exp_v;
    reset_dut();
    for (int c = 0; c < 25; c++) begin
      exp_v = {(c >= 11 && c <= 14), (c >= 11 && c <= 17), 2'd0, 1'b0};
      checks++;
      if ({out, busy, pending, overflow} !== exp_v) begin
        errors++;
        $display("FAIL single c=%0d: got %b expected %b", c, {out, busy, pending, overflow}, exp_v);
      end
      trig = (c == 10);
      tick();
    end
    trig = 1'b0;
  endtask

  task automatic test_queue();
    logic [4:0] exp_v;
    logic [1:0] exp_p;
    reset_dut();
    for (int c = 0; c < 36; c++) begin
      exp_p = (c == 13) ? 2'd1 : (c >= 14 && c <= 17) ? 2'd2 : (c >= 18 && c <= 24) ? 2'd1 : 2'd0;
      exp_v = {((c >= 11 && c <= 14) || (c >= 18 && c <= 21) || (c >= 25 && c <= 28)),
               (c >= 11 && c <= 31), exp_p, 1'b0};
      checks++;
      if ({out, busy, pending, overflow} !== exp_v) begin
        errors++;
        $display("FAIL queue c=%0d: got %b expected %b", c, {out, busy, pending, overflow}, exp_v);
      end
      trig = (c == 10 || c == 12 || c == 13);
      tick();
    end
    trig = 1'b0;
  endtask

  task automatic test_overflow();
    logic [4:0] exp_v;
    logic [1:0] exp_p;
    reset_dut();
    for (int c = 0; c < 46; c++) begin
      exp_p = (c == 12) ? 2'd1 : (c >= 13 && c <= 17) ? 2'd2 : (c >= 18 && c <= 24) ? 2'd1 : 2'd0;
      exp_v = {((c >= 11 && c <= 14) || (c >= 18 && c <= 21) || (c >= 25 && c <= 28)),
               (c >= 11 && c <= 31), exp_p, (c >= 14 && c <= 40)};
      checks++;
      if ({out, busy, pending, overflow} !== exp_v) begin
        errors++;
        $display("FAIL overflow c=%0d: got %b expected %b", c, {out, busy, pending, overflow}, exp_v);
      end
      trig    = (c >= 10 && c <= 13);
      // Clear in the drop cycle must lose to the drop.
      clr_ovf = (c == 13 || c == 40);
      tick();
    end
    trig = 1'b0; clr_ovf = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [4:0] exp_v;
    reset_dut();
    for (int c = 0; c < 30; c++) begin
      exp_v = {((c >= 11 && c <= 14) || (c >= 18 && c <= 21)), (c >= 11 && c <= 24), 2'd0, 1'b0};
      checks++;
      if ({out, busy, pending, overflow} !== exp_v) begin
        errors++;
        $display("FAIL back_to_back c=%0d: got %b expected %b", c, {out, busy, pending, overflow}, exp_v);
      end
      trig = (c == 10 || c == 17);
      tick();
    end
    trig = 1'b0;
  endtask

  task automatic test_rst_mid();
    logic [4:0] exp_v;
    reset_dut();
    for (int c = 0; c < 40; c++) begin
      exp_v = (c == 13) ? 5'b11010 : (c >= 11 && c <= 12) ? 5'b11000 : 5'b00000;
      checks++;
      if ({out, busy, pending, overflow} !== exp_v) begin
        errors++;
        $display("FAIL rst_mid c=%0d: got %b expected %b", c, {out, busy, pending, overflow}, exp_v);
      end
      trig = (c == 10 || c == 12);
      rst  = (c == 13);
      tick();
    end
    trig = 1'b0; rst = 1'b0;
  endtask

  task automatic test_defaults();
    int  pulses = 0;
    int  high_len = 0;
    int  low_len = 0;
    logic prev = 1'b0;
    d_rst = 1'b1; d_trig = 1'b0; d_clr_ovf = 1'b0;
    repeat (2) tick();
    d_rst = 1'b0;
    for (int c = 0; c < 8400; c++) begin
      if (d_out && !prev) begin
        pulses++;
        if (pulses > 1) begin
          checks++;
          if (low_len !== 255) begin
            errors++;
            $display("FAIL default_gap pulse=%0d: got %0d expected 255", pulses, low_len);
          end
        end
        high_len = 0;
      end else if (!d_out && prev) begin
        checks++;
        if (high_len !== 255) begin
          errors++;
          $display("FAIL default_high pulse=%0d: got %0d expected 255", pulses, high_len);
        end
        low_len = 0;
      end
      if (d_out) high_len++; else low_len++;
      prev = d_out;
      if (c == 30) begin
        checks++;
        if (d_pending !== 4'd15) begin
          errors++;
          $display("FAIL default_saturate: got %0d expected 15", d_pending);
        end
      end
      d_trig = (c >= 10 && c <= 29);
      tick();
    end
    d_trig = 1'b0;
    checks++;
    if (pulses !== 16) begin
      errors++;
      $display("FAIL default_pulse_count: got %0d expected 16", pulses);
    end
    checks++;
    if ({d_busy, d_pending, d_overflow} !== 6'b000001) begin
      errors++;
      $display("FAIL default_end_state: got %b expected 000001", {d_busy, d_pending, d_overflow});
    end
  endtask

  initial begin
    d_rst = 1'b1; d_trig = 1'b0; d_clr_ovf = 1'b0;
    test_reset();
    test_single();
    test_queue();
    test_overflow();
    test_back_to_back();
    test_rst_mid();
    test_defaults();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
